// File: rtl/instr_loader.sv
// Instruction loader: parses a framed byte stream (length, 16-bit words, XOR checksum),
// writes the words into instruction memory and holds the core in reset until a good frame lands.
module instr_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  // Largest word count that fits between BASE_ADDR and the top of the address space.
  localparam int unsigned MaxWords = (32'd1 << ADDR_W) - BASE_ADDR;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StCsum,
    StDone,
    StError
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          csum_q, csum_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [15:0]         wdata_q, wdata_d;

  logic                accept;
  logic                start_ok;
  logic [15:0]         len_full;
  logic                len_too_big;
  logic                last_word;

  assign accept      = in_valid & in_ready;
  assign start_ok    = start & ((state_q == StIdle) | (state_q == StDone) | (state_q == StError));
  assign len_full    = {len_q[15:8], in_data};
  assign len_too_big = 32'(len_full) > MaxWords;
  assign last_word   = (32'(words_q) + 32'd1) == 32'(len_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StError: begin
        if (start) state_d = StLenHi;
      end
      StLenHi: begin
        if (accept) state_d = StLenLo;
      end
      StLenLo: begin
        if (accept) begin
          if (len_too_big) begin
            state_d = StError;
          end else if (len_full == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (accept) state_d = StDataLo;
      end
      StDataLo: begin
        if (accept) state_d = last_word ? StCsum : StDataHi;
      end
      StCsum: begin
        if (accept) state_d = (in_data == csum_q) ? StDone : StError;
      end
      default: state_d = StIdle;
    endcase
  end

  // State decodes
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      StLenHi, StLenLo, StDataHi, StDataLo, StCsum: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StDone:  done = 1'b1;
      StError: err  = 1'b1;
      default: ;
    endcase
    cpu_rst = ~done;
  end

  // Datapath next-state: checksum covers every frame byte except the checksum itself
  always_comb begin
    len_d    = len_q;
    hi_d     = hi_q;
    csum_d   = csum_q;
    words_d  = words_q;
    mem_we_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (start_ok) begin
      len_d   = '0;
      csum_d  = '0;
      words_d = '0;
    end
    if (accept) begin
      if (state_q != StCsum) csum_d = csum_q ^ in_data;
      case (state_q)
        StLenHi:  len_d[15:8] = in_data;
        StLenLo:  len_d[7:0]  = in_data;
        StDataHi: hi_d        = in_data;
        StDataLo: begin
          mem_we_d = 1'b1;
          waddr_d  = ADDR_W'(BASE_ADDR) + words_q[ADDR_W-1:0];
          wdata_d  = {hi_q, in_data};
          words_d  = words_q + (ADDR_W + 1)'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      hi_q     <= '0;
      csum_q   <= '0;
      words_q  <= '0;
      mem_we_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      len_q    <= len_d;
      hi_q     <= hi_d;
      csum_q   <= csum_d;
      words_q  <= words_d;
      mem_we_q <= mem_we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_waddr    = waddr_q;
  assign mem_wdata    = wdata_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: table of frames on a BASE_ADDR=0 instance plus
// hand sequences for reset mid-frame, busy start, back-to-back start and the length limit.
module tb_instr_loader;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] data;
  logic start_a, valid_a, start_b, valid_b;

  logic          ready_a, we_a, cpu_rst_a, busy_a, done_a, err_a;
  logic [AW-1:0] waddr_a;
  logic [15:0]   wdata_a;
  logic [AW:0]   words_a;
  logic          ready_b, we_b, cpu_rst_b, busy_b, done_b, err_b;
  logic [AW-1:0] waddr_b;
  logic [15:0]   wdata_b;
  logic [AW:0]   words_b;

  instr_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_data(data), .in_valid(valid_a),
    .in_ready(ready_a), .mem_we(we_a), .mem_waddr(waddr_a), .mem_wdata(wdata_a),
    .cpu_rst(cpu_rst_a), .busy(busy_a), .done(done_a), .err(err_a), .words_loaded(words_a)
  );

  instr_loader #(.ADDR_W(AW), .BASE_ADDR(1000)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_data(data), .in_valid(valid_b),
    .in_ready(ready_b), .mem_we(we_b), .mem_waddr(waddr_b), .mem_wdata(wdata_b),
    .cpu_rst(cpu_rst_b), .busy(busy_b), .done(done_b), .err(err_b), .words_loaded(words_b)
  );

  always #5 clk = ~clk;

  // Write logs, sampled on the falling edge
  logic [AW-1:0] wa_addr[$];
  logic [15:0]   wa_data[$];
  logic [AW-1:0] wb_addr[$];
  logic [15:0]   wb_data[$];
  always @(negedge clk) begin
    if (we_a) begin wa_addr.push_back(waddr_a); wa_data.push_back(wdata_a); end
    if (we_b) begin wb_addr.push_back(waddr_b); wb_data.push_back(wdata_b); end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Present one byte after `gap` idle cycles; returns #1 after the accepting edge
  task automatic send(input bit sel, input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin @(posedge clk); #1; end
    data = b;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    t = 0;
    while (!(sel ? ready_b : ready_a) && t < 20) begin @(posedge clk); #1; t++; end
    check("in_ready", 32'(sel ? ready_b : ready_a), 1);
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  bytes [9];
    int          nbytes;
    bit          gapped;
    bit          exp_done;
    int          exp_words;
    int          exp_nw;
    logic [15:0] exp_addr [3];
    logic [15:0] exp_data [3];
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  initial begin
    logic [7:0] cs;
    logic [7:0] hb, lb;
    int nw;

    // Frame table: checksums are XOR of all preceding bytes
    vecs[0] = '{bytes: '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'h00, 8'h00},
                nbytes: 7, gapped: 0, exp_done: 1, exp_words: 2, exp_nw: 2,
                exp_addr: '{16'd0, 16'd1, 16'd0}, exp_data: '{16'h1234, 16'hABCD, 16'h0}};
    vecs[1] = vecs[0];
    vecs[1].gapped = 1;
    vecs[2] = vecs[0];
    vecs[2].bytes[6] = 8'h43;
    vecs[2].exp_done = 0;
    vecs[3] = vecs[0];
    vecs[4] = '{bytes: '{8'h00, 8'h01, 8'h5A, 8'hA5, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00},
                nbytes: 5, gapped: 1, exp_done: 1, exp_words: 1, exp_nw: 1,
                exp_addr: '{16'd0, 16'd0, 16'd0}, exp_data: '{16'h5AA5, 16'h0, 16'h0}};
    vecs[5] = '{bytes: '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h74},
                nbytes: 9, gapped: 0, exp_done: 1, exp_words: 3, exp_nw: 3,
                exp_addr: '{16'd0, 16'd1, 16'd2}, exp_data: '{16'h1122, 16'h3344, 16'h5566}};

    rst = 1'b1; data = 8'h00;
    start_a = 1'b0; valid_a = 1'b0; start_b = 1'b0; valid_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 32'(ready_a), 0);
    check("rst mem_we", 32'(we_a), 0);
    check("rst mem_waddr", 32'(waddr_a), 0);
    check("rst mem_wdata", 32'(wdata_a), 0);
    check("rst cpu_rst", 32'(cpu_rst_a), 1);
    check("rst busy", 32'(busy_a), 0);
    check("rst done", 32'(done_a), 0);
    check("rst err", 32'(err_a), 0);
    check("rst words", 32'(words_a), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset after 3 of 5 bytes of an N=1 frame
    pulse_start(0);
    send(0, 8'h00, 0);
    send(0, 8'h01, 0);
    send(0, 8'h77, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst busy", 32'(busy_a), 0);
    check("midrst cpu_rst", 32'(cpu_rst_a), 1);
    check("midrst words", 32'(words_a), 0);
    check("midrst writes", 32'(wa_addr.size()), 0);

    for (int v = 0; v < NV; v++) begin
      wa_addr.delete();
      wa_data.delete();
      pulse_start(0);
      check($sformatf("v%0d busy after start", v), 32'(busy_a), 1);
      check($sformatf("v%0d cpu_rst after start", v), 32'(cpu_rst_a), 1);
      for (int k = 0; k < vecs[v].nbytes; k++)
        send(0, vecs[v].bytes[k], vecs[v].gapped ? int'($urandom_range(0, 3)) : 0);
      @(posedge clk); #1;
      check($sformatf("v%0d done", v), 32'(done_a), 32'(vecs[v].exp_done));
      check($sformatf("v%0d err", v), 32'(err_a), 32'(!vecs[v].exp_done));
      check($sformatf("v%0d cpu_rst", v), 32'(cpu_rst_a), 32'(!vecs[v].exp_done));
      check($sformatf("v%0d busy", v), 32'(busy_a), 0);
      check($sformatf("v%0d words", v), 32'(words_a), 32'(vecs[v].exp_words));
      check($sformatf("v%0d write count", v), 32'(wa_addr.size()), 32'(vecs[v].exp_nw));
      nw = (wa_addr.size() < vecs[v].exp_nw) ? wa_addr.size() : vecs[v].exp_nw;
      for (int w = 0; w < nw; w++) begin
        check($sformatf("v%0d w%0d addr", v, w), 32'(wa_addr[w]), 32'(vecs[v].exp_addr[w]));
        check($sformatf("v%0d w%0d data", v, w), 32'(wa_data[w]), 32'(vecs[v].exp_data[w]));
      end
    end

    // Zero-length frame with an ignored start while busy, then back-to-back start from DONE
    wa_addr.delete();
    wa_data.delete();
    pulse_start(0);
    send(0, 8'h00, 0);
    pulse_start(0);
    send(0, 8'h00, 0);
    send(0, 8'h00, 0);
    check("zero done", 32'(done_a), 1);
    check("zero cpu_rst", 32'(cpu_rst_a), 0);
    check("zero words", 32'(words_a), 0);
    check("zero writes", 32'(wa_addr.size()), 0);
    pulse_start(0);
    check("b2b busy", 32'(busy_a), 1);
    check("b2b cpu_rst", 32'(cpu_rst_a), 1);
    check("b2b done", 32'(done_a), 0);

    // Length limit at BASE_ADDR=1000: N=25 too long, N=24 fills 1000..1023
    pulse_start(1);
    send(1, 8'h00, 0);
    send(1, 8'h19, 0);
    check("len25 err", 32'(err_b), 1);
    check("len25 busy", 32'(busy_b), 0);
    check("len25 cpu_rst", 32'(cpu_rst_b), 1);
    @(posedge clk); #1;
    check("len25 writes", 32'(wb_addr.size()), 0);

    pulse_start(1);
    cs = 8'h00 ^ 8'h18;
    send(1, 8'h00, 0);
    send(1, 8'h18, 0);
    for (int i = 0; i < 24; i++) begin
      hb = 8'(i + 1);
      lb = 8'hF0 ^ 8'(i);
      cs = cs ^ hb ^ lb;
      send(1, hb, 0);
      send(1, lb, 0);
    end
    send(1, cs, 0);
    @(posedge clk); #1;
    check("len24 done", 32'(done_b), 1);
    check("len24 err", 32'(err_b), 0);
    check("len24 words", 32'(words_b), 24);
    check("len24 write count", 32'(wb_addr.size()), 24);
    nw = (wb_addr.size() < 24) ? wb_addr.size() : 24;
    for (int i = 0; i < nw; i++) begin
      hb = 8'(i + 1);
      lb = 8'hF0 ^ 8'(i);
      check($sformatf("len24 w%0d addr", i), 32'(wb_addr[i]), 32'(1000 + i));
      check($sformatf("len24 w%0d data", i), 32'(wb_data[i]), 32'({hb, lb}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule
